// File: rtl/reg_slice_rr_arbiter.sv
// Round-robin packet arbiter: locks onto one requester for a whole packet
// and feeds a 2-entry output slice that sustains one beat per cycle.
module reg_slice_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic            busy
);

  // state | meaning
  // IDLE  | no grant; searching for the next requester from rr_ptr
  // LOCK  | grant g held until its last beat is accepted
  typedef enum logic {S_IDLE, S_LOCK} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        g_q, g_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0][W-1:0]    ent_data_q, ent_data_d;
  logic [1:0]           ent_last_q, ent_last_d;
  logic [1:0][IW-1:0]   ent_id_q, ent_id_d;
  logic [1:0]           ent_vld_q, ent_vld_d;
  logic                 wptr_q, wptr_d;
  logic                 rptr_q, rptr_d;

  logic                 found;
  logic [IW-1:0]        pick;
  logic [IW-1:0]        idx;
  logic [W-1:0]         sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 has_space;
  logic                 wr_en;
  logic                 rd_en;

  // First valid requester at or above rr_ptr, wrapping past N-1.
  always_comb begin
    found = 1'b0;
    pick  = g_q;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % N);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g_q == IW'(i)) sel_data = req_data[i*W +: W];
    end
  end

  assign sel_valid = req_valid[g_q];
  assign sel_last  = req_last[g_q];
  assign has_space = ~(&ent_vld_q);
  assign busy      = (state_q == S_LOCK);
  assign wr_en     = busy && sel_valid && has_space;
  assign out_valid = |ent_vld_q;
  assign rd_en     = out_valid && out_ready;
  assign out_data  = ent_data_q[rptr_q];
  assign out_last  = ent_last_q[rptr_q];
  assign out_id    = ent_id_q[rptr_q];

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[g_q] = has_space;
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_ptr_d   = rr_ptr_q;
    ent_data_d = ent_data_q;
    ent_last_d = ent_last_q;
    ent_id_d   = ent_id_q;
    ent_vld_d  = ent_vld_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d     = pick;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (wr_en && sel_last) begin
          state_d  = S_IDLE;
          rr_ptr_d = (g_q == IW'(N-1)) ? '0 : g_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Write never targets the read entry: full blocks writes, empty blocks reads.
    if (wr_en) begin
      ent_data_d[wptr_q] = sel_data;
      ent_last_d[wptr_q] = sel_last;
      ent_id_d[wptr_q]   = g_q;
      ent_vld_d[wptr_q]  = 1'b1;
      wptr_d             = ~wptr_q;
    end
    if (rd_en) begin
      ent_vld_d[rptr_q] = 1'b0;
      rptr_d            = ~rptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      rr_ptr_q   <= '0;
      ent_data_q <= '0;
      ent_last_q <= '0;
      ent_id_q   <= '0;
      ent_vld_q  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_ptr_q   <= rr_ptr_d;
      ent_data_q <= ent_data_d;
      ent_last_q <= ent_last_d;
      ent_id_q   <= ent_id_d;
      ent_vld_q  <= ent_vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

endmodule

// File: tb/tb_reg_slice_rr_arbiter.sv
// Scoreboard bench for reg_slice_rr_arbiter: directed packets per requester,
// expected output beats queued up front and checked by a separate monitor.
module tb_reg_slice_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            out_ready;
  logic            busy;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  beat_t      sb[$];
  logic [W:0] src[N][$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  reg_slice_rr_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_id(out_id), .out_ready(out_ready), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = src[i][0][W-1:0];
        req_last[i]          = src[i][0][W];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*W +: W]   = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(src[i].pop_front());
    end
    drive();
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    src[r].push_back({l, d});
  endtask

  task automatic expect_beat(input int r, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.id   = IW'(r);
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  function automatic bit src_busy();
    bit any = 1'b0;
    for (int i = 0; i < N; i++) if (src[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((sb.size() != 0 || src_busy() || out_valid || busy) && cyc < 200) begin
      step();
      cyc++;
    end
    chk({name, "_drain_timeout"}, (cyc >= 200), 0);
    chk({name, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, "_req_ready"}, req_ready, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_data"},  out_data,  0);
    chk({name, "_out_last"},  out_last,  0);
    chk({name, "_out_id"},    out_id,    0);
    chk({name, "_busy"},      busy,      0);
    sb.delete();
    for (int i = 0; i < N; i++) src[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: a beat transfers at the next rising edge when valid&ready now.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got id=%0d data=0x%0h last=%0b expected no beat",
                   out_id, out_data, out_last);
        end else begin
          e = sb.pop_front();
          if ({out_id, out_data, out_last} !== e) begin
            n_err++;
            $display("FAIL sb_beat: got id=%0d data=0x%0h last=%0b expected id=%0d data=0x%0h last=%0b",
                     out_id, out_data, out_last, e.id, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    @(posedge clk);
    #1;
    do_reset("por");

    // Fair rotation, single-beat packets
    out_ready = 1'b1;
    push(0, 8'hA0, 1'b1); push(0, 8'hA4, 1'b1);
    push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
    expect_beat(0, 8'hA0, 1'b1); expect_beat(1, 8'hA1, 1'b1);
    expect_beat(2, 8'hA2, 1'b1); expect_beat(3, 8'hA3, 1'b1);
    expect_beat(0, 8'hA4, 1'b1);
    drive();
    wait_drain("rot");

    // Packet lock with a competing requester
    do_reset("rst2");
    out_ready = 1'b1;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(1, 8'h20, 1'b1);
    expect_beat(0, 8'h10, 1'b0); expect_beat(0, 8'h11, 1'b0);
    expect_beat(0, 8'h12, 1'b1); expect_beat(1, 8'h20, 1'b1);
    drive();
    step();
    chk("lock_busy", busy, 1);
    chk("lock_req_ready", req_ready, 4'b0001);
    wait_drain("lock");

    // Backpressure on a 4-beat packet from req2 (rr_ptr now 2)
    out_ready = 1'b0;
    push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b0); push(2, 8'h32, 1'b0); push(2, 8'h33, 1'b1);
    expect_beat(2, 8'h30, 1'b0); expect_beat(2, 8'h31, 1'b0);
    expect_beat(2, 8'h32, 1'b0); expect_beat(2, 8'h33, 1'b1);
    drive();
    repeat (8) step();
    chk("bp_left", src[2].size(), 2);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_id", out_id, 2);
    chk("bp_out_data", out_data, 8'h30);
    repeat (2) step();
    chk("bp_hold_data", out_data, 8'h30);
    out_ready = 1'b1;
    wait_drain("bp");

    // Read and write at full occupancy, req3 (rr_ptr now 3)
    out_ready = 1'b0;
    push(3, 8'h40, 1'b0); push(3, 8'h41, 1'b0); push(3, 8'h42, 1'b0);
    push(3, 8'h43, 1'b0); push(3, 8'h44, 1'b1);
    expect_beat(3, 8'h40, 1'b0); expect_beat(3, 8'h41, 1'b0); expect_beat(3, 8'h42, 1'b0);
    expect_beat(3, 8'h43, 1'b0); expect_beat(3, 8'h44, 1'b1);
    drive();
    repeat (6) step();
    chk("full_left", src[3].size(), 3);
    chk("full_req_ready", req_ready, 0);
    out_ready = 1'b1;
    step();
    chk("full_ready_after_read", req_ready, 4'b1000);
    repeat (3) step();
    chk("full_throughput", src[3].size(), 0);
    wait_drain("full");

    // Wrap search: bring rr_ptr to 3, then only req1
    push(0, 8'h50, 1'b1); push(1, 8'h51, 1'b1); push(2, 8'h52, 1'b1);
    expect_beat(0, 8'h50, 1'b1); expect_beat(1, 8'h51, 1'b1); expect_beat(2, 8'h52, 1'b1);
    drive();
    wait_drain("pre_wrap");
    push(1, 8'h60, 1'b1);
    expect_beat(1, 8'h60, 1'b1);
    drive();
    wait_drain("wrap");
    push(1, 8'h61, 1'b1); push(2, 8'h62, 1'b1);
    expect_beat(2, 8'h62, 1'b1); expect_beat(1, 8'h61, 1'b1);
    drive();
    wait_drain("wrap_ptr");
    push(2, 8'h63, 1'b1);
    expect_beat(2, 8'h63, 1'b1);
    drive();
    wait_drain("to_ptr3");

    // Mid-packet reset on req0, then fresh search from 0
    out_ready = 1'b0;
    push(0, 8'h70, 1'b0); push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
    drive();
    repeat (5) step();
    chk("mr_left", src[0].size(), 2);
    chk("mr_busy", busy, 1);
    do_reset("mid");
    out_ready = 1'b1;
    push(3, 8'h81, 1'b1); push(2, 8'h80, 1'b1);
    expect_beat(2, 8'h80, 1'b1); expect_beat(3, 8'h81, 1'b1);
    drive();
    step();
    chk("mr_grant", req_ready, 4'b0100);
    wait_drain("mr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_slice_rr_arbiter.md
REG_SLICE_RR_ARBITER -- requirements
Module: reg_slice_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter W, default 8: data width per beat; minimum 1.
REQ-003 Parameter IW, default 2: grant-id width; SHALL equal ceil(log2(N)).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  N  per-requester beat valid.
REQ-007 req_data  input  N*W  per-requester beat data; requester i occupies bits [i*W +: W].
REQ-008 req_last  input  N  per-requester end-of-packet flag.
REQ-009 req_ready  output  N  per-requester beat accept.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_data  output  W  output beat data.
REQ-012 out_last  output  1  output end-of-packet flag.
REQ-013 out_id  output  IW  index of the requester that sourced the output beat.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 busy  output  1  high while a packet is locked (state LOCK).

Function
REQ-016 Transfer on any port SHALL occur only on a cycle where valid and ready are both high at the rising edge.
REQ-017 The block SHALL have two states: IDLE (no grant) and LOCK (grant held).
REQ-018 In IDLE, all req_ready bits SHALL be 0.
REQ-019 In IDLE with any req_valid high, the block SHALL register grant g and enter LOCK next cycle.
REQ-020 g SHALL be the first index with req_valid high, searching upward from rr_ptr and wrapping N-1 to 0.
REQ-021 In IDLE with no req_valid high, the state SHALL remain IDLE and g SHALL be unchanged.
REQ-022 In LOCK, req_ready[g] SHALL equal buf_has_space; all other req_ready bits SHALL be 0.
REQ-023 buf_has_space SHALL be 1 when the buffer holds fewer than 2 entries (combinational, no dependency on out_ready).
REQ-024 Accepted beats SHALL be written into an internal 2-entry buffer as {data, last, g}.
REQ-025 The buffer SHALL use 1-bit write and read pointers and a per-entry valid flag.
REQ-026 out_valid SHALL be high when any entry is valid.
REQ-027 out_data, out_last and out_id SHALL come from the entry at the read pointer.
REQ-028 Simultaneous write and read on the same cycle SHALL be permitted at any occupancy, including full, where a read frees a slot only for the next cycle.
REQ-029 Latency: a beat accepted at edge t SHALL be visible on the outputs after edge t, with no bubble.
REQ-030 Sustained throughput within a packet SHALL be 1 beat per cycle while out_ready=1.
REQ-031 When a beat with req_last=1 is accepted in LOCK, the state SHALL return to IDLE and rr_ptr SHALL become (g+1) mod N.
REQ-032 Minimum gap between packets SHALL be one IDLE cycle.
REQ-033 A single-beat packet (last on its first beat) SHALL be legal.
REQ-034 In LOCK, the grant SHALL NOT change while req_valid[g] is low; the block waits indefinitely.
REQ-035 Changes on other requesters' inputs during LOCK SHALL have no effect.
REQ-036 Packet beats SHALL never interleave on the output; order per requester SHALL be preserved.
REQ-037 out_valid SHALL stay high and the output fields stable until accepted (no retraction).

Reset
REQ-038 While rst_n=0, the state SHALL be IDLE and rr_ptr, g and both pointers SHALL be 0.
REQ-039 While rst_n=0, entry valid flags SHALL be 0 and entry data, last and id SHALL be 0.
REQ-040 Resulting outputs SHALL be req_ready=0, out_valid=0, out_data=0, out_last=0, out_id=0, busy=0.
REQ-041 Reset asserted mid-packet SHALL discard buffered beats and the lock; a partial packet is not completed.

Verification
REQ-042 Fair rotation: N=4, all req_valid=1 with 1-beat packets, out_ready=1 -> out_id sequence 0,1,2,3,0.
REQ-043 Packet lock: req0 sends 3 beats (data 0x10,0x11,0x12, last on 0x12) while req1 is valid -> out shows 0x10,0x11,0x12 with id 0, then req1's beat.
REQ-044 Backpressure: out_ready=0 during a 4-beat packet -> exactly 2 beats accepted and req_ready[g] drops to 0; out_ready=1 -> remaining beats follow in order, none lost or duplicated.
REQ-045 Simultaneous read and write at full: buffer full, out_ready=1, req_valid=1 -> read completes and req_ready is high the following cycle; steady state is 1 beat per cycle.
REQ-046 Wrap search: rr_ptr=3, only req1 valid -> grant 1, then rr_ptr=2.
REQ-047 Mid-packet reset: assert rst_n=0 after 2 beats -> all outputs 0 immediately; after release, a new request from req2 is granted first via search from 0.
